// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_MUL  = 3'd1;
   localparam logic [2:0] ST_DIV  = 3'd2;
   localparam logic [2:0] ST_FIX  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   localparam int DIV_ITER = 32;

   localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

   // Two's complement magnitude; -2^31 maps to 0x80000000 read as unsigned.
   function automatic logic [31:0] mag32(input logic [31:0] v);
      return v[31] ? -v : v;
   endfunction

endpackage

// File: rtl/hilo_muldiv_seq_if.sv
// Request/result bundle between the operand buses and the HI/LO unit.
interface hilo_muldiv_seq_if #(parameter int WIDTH = 32);

   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b,
                   input  busy, done, div_by_zero, hi, lo);

   modport slave  (input  start, op, a, b,
                   output busy, done, div_by_zero, hi, lo);

endinterface

// File: rtl/booth_32x32_mult.sv
// Combinational radix-4 Booth signed 32x32 -> 64 multiplier.
module booth_32x32_mult (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] product
);

   logic [32:0] bb;
   logic [63:0] ax;
   logic [63:0] pp;

   // Each Booth digit in {-2..+2} selects a multiple of the sign-extended multiplicand.
   always_comb begin
      bb      = {b, 1'b0};
      ax      = {{32{a[31]}}, a};
      pp      = '0;
      product = '0;
      for (int i = 0; i < 16; i++) begin
         case (bb[2*i +: 3])
            3'b001, 3'b010: pp = ax;
            3'b011:         pp = ax << 1;
            3'b100:         pp = -(ax << 1);
            3'b101, 3'b110: pp = -ax;
            default:        pp = '0;
         endcase
         product = product + (pp << (2 * i));
      end
   end

endmodule

// File: rtl/hilo_muldiv_seq.sv
// Sequential MUL/DIV unit owning HI/LO: one-cycle Booth multiply, 32-step restoring divide.
module hilo_muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic              clock,
   input  logic              clear,
   hilo_muldiv_seq_if.slave  bus
);

   localparam int CNT_W = $clog2(DIV_ITER);

   logic [2:0]         state;
   logic [2:0]         state_nx;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   babs;
   logic [2*WIDTH-1:0] rq;
   logic [2*WIDTH-1:0] rq_step;
   logic [2*WIDTH-1:0] shifted;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] product;
   logic [CNT_W-1:0]   cnt;
   logic               accept;

   booth_32x32_mult u_mult (
      .a       (a_q),
      .b       (b_q),
      .product (product)
   );

   assign accept = bus.start && (state == ST_IDLE || state == ST_DONE);

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               if (bus.op == OP_MUL)
                  state_nx = ST_MUL;
               else if (bus.b == '0)
                  state_nx = ST_FIX;
               else
                  state_nx = ST_DIV;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_MUL:  state_nx = ST_DONE;
         ST_DIV:  state_nx = (cnt == CNT_W'(DIV_ITER - 1)) ? ST_FIX : ST_DIV;
         ST_FIX:  state_nx = ST_DONE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // rq holds remainder:quotient; a non-borrowing trial subtract shifts in a 1.
   always_comb begin
      shifted = {rq[2*WIDTH-2:0], 1'b0};
      diff    = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, babs};
      rq_step = diff[WIDTH] ? shifted
                            : {diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state           <= ST_IDLE;
         bus.hi          <= '0;
         bus.lo          <= '0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.div_by_zero <= 1'b0;
         a_q             <= '0;
         b_q             <= '0;
         babs            <= '0;
         rq              <= '0;
         cnt             <= '0;
      end else begin
         state    <= state_nx;
         bus.busy <= (state_nx == ST_MUL) || (state_nx == ST_DIV) || (state_nx == ST_FIX);
         bus.done <= (state_nx == ST_DONE);

         if (accept) begin
            a_q             <= bus.a;
            b_q             <= bus.b;
            babs            <= mag32(bus.b);
            rq              <= {{WIDTH{1'b0}}, mag32(bus.a)};
            cnt             <= '0;
            bus.div_by_zero <= 1'b0;
         end

         case (state)
            ST_MUL: {bus.hi, bus.lo} <= product;
            ST_DIV: begin
               rq  <= rq_step;
               cnt <= cnt + 1'b1;
            end
            ST_FIX: begin
               if (b_q == '0) begin
                  bus.lo          <= DIV_BY_ZERO_LO;
                  bus.hi          <= a_q;
                  bus.div_by_zero <= 1'b1;
               end else begin
                  bus.lo <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -rq[WIDTH-1:0] : rq[WIDTH-1:0];
                  bus.hi <= a_q[WIDTH-1] ? -rq[2*WIDTH-1:WIDTH] : rq[2*WIDTH-1:WIDTH];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Directed self-checking bench for hilo_muldiv_seq.
module tb_hilo_muldiv_seq;

   logic clock;
   logic clear;
   int   checks;
   int   errors;
   int   pulses;

   hilo_muldiv_seq_if #(.WIDTH(32)) bus ();

   hilo_muldiv_seq #(.WIDTH(32)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      tick(1);
      bus.start = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      pulses    = 0;
      bus.start = 1'b0;
      bus.op    = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      clear     = 1'b1;
      tick(2);
      clear = 1'b0;
      checkOutput("reset_hi", bus.hi, 32'h0);
      checkOutput("reset_lo", bus.lo, 32'h0);
      checkOutput("reset_busy", {31'b0, bus.busy}, 32'h0);
      checkOutput("reset_done", {31'b0, bus.done}, 32'h0);
      checkOutput("reset_dbz", {31'b0, bus.div_by_zero}, 32'h0);

      // MUL 7 * -3
      applyStimulus(1'b0, 32'd7, 32'hFFFF_FFFD);
      checkOutput("mul1_busy", {31'b0, bus.busy}, 32'h1);
      checkOutput("mul1_done_early", {31'b0, bus.done}, 32'h0);
      tick(1);
      checkOutput("mul1_done", {31'b0, bus.done}, 32'h1);
      checkOutput("mul1_busy_off", {31'b0, bus.busy}, 32'h0);
      checkOutput("mul1_hi", bus.hi, 32'hFFFF_FFFF);
      checkOutput("mul1_lo", bus.lo, 32'hFFFF_FFEB);
      tick(1);
      checkOutput("mul1_done_pulse", {31'b0, bus.done}, 32'h0);

      // MUL -2^31 * -2^31 with a start issued while busy
      applyStimulus(1'b0, 32'h8000_0000, 32'h8000_0000);
      bus.start = 1'b1;
      bus.a     = 32'd3;
      bus.b     = 32'd3;
      tick(1);
      bus.start = 1'b0;
      checkOutput("mul2_done", {31'b0, bus.done}, 32'h1);
      checkOutput("mul2_hi", bus.hi, 32'h4000_0000);
      checkOutput("mul2_lo", bus.lo, 32'h0);
      tick(1);
      checkOutput("mul2_not_queued_busy", {31'b0, bus.busy}, 32'h0);
      checkOutput("mul2_not_queued_done", {31'b0, bus.done}, 32'h0);

      // DIV -7 / 2
      applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);
      checkOutput("div1_busy", {31'b0, bus.busy}, 32'h1);
      tick(32);
      checkOutput("div1_busy_e33", {31'b0, bus.busy}, 32'h1);
      checkOutput("div1_done_e33", {31'b0, bus.done}, 32'h0);
      checkOutput("div1_hi_hold", bus.hi, 32'h4000_0000);
      tick(1);
      checkOutput("div1_done", {31'b0, bus.done}, 32'h1);
      checkOutput("div1_lo", bus.lo, 32'hFFFF_FFFD);
      checkOutput("div1_hi", bus.hi, 32'hFFFF_FFFF);
      checkOutput("div1_dbz", {31'b0, bus.div_by_zero}, 32'h0);
      tick(1);

      // DIV 100 / 0
      applyStimulus(1'b1, 32'd100, 32'd0);
      checkOutput("dbz_busy", {31'b0, bus.busy}, 32'h1);
      tick(1);
      checkOutput("dbz_done", {31'b0, bus.done}, 32'h1);
      checkOutput("dbz_lo", bus.lo, 32'hFFFF_FFFF);
      checkOutput("dbz_hi", bus.hi, 32'd100);
      checkOutput("dbz_flag", {31'b0, bus.div_by_zero}, 32'h1);
      tick(1);
      checkOutput("dbz_flag_hold", {31'b0, bus.div_by_zero}, 32'h1);
      applyStimulus(1'b0, 32'd2, 32'd3);
      checkOutput("dbz_flag_cleared", {31'b0, bus.div_by_zero}, 32'h0);
      tick(1);
      checkOutput("mul3_lo", bus.lo, 32'd6);
      tick(1);

      // DIV -2^31 / -1, then back-to-back MUL 5 * 6 accepted in DONE
      applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      tick(33);
      checkOutput("ovf_done", {31'b0, bus.done}, 32'h1);
      checkOutput("ovf_lo", bus.lo, 32'h8000_0000);
      checkOutput("ovf_hi", bus.hi, 32'h0);
      applyStimulus(1'b0, 32'd5, 32'd6);
      checkOutput("b2b_busy", {31'b0, bus.busy}, 32'h1);
      checkOutput("b2b_done_low", {31'b0, bus.done}, 32'h0);
      tick(1);
      checkOutput("b2b_done", {31'b0, bus.done}, 32'h1);
      checkOutput("b2b_lo", bus.lo, 32'd30);
      checkOutput("b2b_hi", bus.hi, 32'd0);
      tick(1);

      // DIV 1000 / 7 aborted by clear at edge 10, then rerun
      applyStimulus(1'b1, 32'd1000, 32'd7);
      tick(8);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      checkOutput("abort_busy", {31'b0, bus.busy}, 32'h0);
      checkOutput("abort_done", {31'b0, bus.done}, 32'h0);
      checkOutput("abort_hi", bus.hi, 32'h0);
      checkOutput("abort_lo", bus.lo, 32'h0);
      for (int i = 0; i < 40; i++) begin
         tick(1);
         if (bus.done === 1'b1) pulses++;
      end
      checkOutput("abort_no_done_pulse", pulses, 32'd0);
      applyStimulus(1'b1, 32'd1000, 32'd7);
      tick(33);
      checkOutput("div2_done", {31'b0, bus.done}, 32'h1);
      checkOutput("div2_lo", bus.lo, 32'd142);
      checkOutput("div2_hi", bus.hi, 32'd6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
